// File: rtl/nn_pkg.sv
// nn_pkg: shared Q2.14 constants and MAC engine state encoding
package nn_pkg;
   localparam int Q_WIDTH = 16;
   localparam int Q_FRAC = 14;
   localparam logic signed [Q_WIDTH-1:0] Q_MAX = 16'sh7fff;
   localparam logic signed [Q_WIDTH-1:0] Q_MIN = 16'sh8000;
   typedef enum logic [1:0] {ACCUM, DRAIN, BIAS, OUT} state_t;
endpackage

// File: rtl/q_round_sat.sv
// q_round_sat: round-half-up, saturate and optional ReLU from accumulator to Q2.14
module q_round_sat import nn_pkg::*; #(
   parameter int ACC_WIDTH = 43,
   parameter int WIDTH = Q_WIDTH,
   parameter int FRAC = Q_FRAC,
   parameter bit RELU = 1'b1
) (
   input  logic signed [ACC_WIDTH-1:0] s,
   output logic [WIDTH-1:0]            r
);
   localparam logic signed [ACC_WIDTH-1:0] HALF = $signed(ACC_WIDTH'(1) << (FRAC-1));
   localparam logic signed [ACC_WIDTH-1:0] MAXE = ACC_WIDTH'(Q_MAX);
   localparam logic signed [ACC_WIDTH-1:0] MINE = ACC_WIDTH'(Q_MIN);
   logic signed [ACC_WIDTH-1:0] t;
   always_comb begin
      t = (s + HALF) >>> FRAC;
      r = (RELU && t[ACC_WIDTH-1]) ? '0 : (t > MAXE) ? Q_MAX : (t < MINE) ? Q_MIN : t[WIDTH-1:0];
   end
endmodule

// File: rtl/neuron_mac_engine.sv
// neuron_mac_engine: streams activations against weight memory, adds bias, emits one Q2.14 result per vector
module neuron_mac_engine import nn_pkg::*; #(
   parameter int NUM_INPUTS = 1024,
   parameter int WIDTH = Q_WIDTH,
   parameter int FRAC = Q_FRAC,
   parameter int ADDR_WIDTH = $clog2(NUM_INPUTS+1),
   parameter int ACC_WIDTH = 2*WIDTH+ADDR_WIDTH,
   parameter bit RELU = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  x_valid,
   input  logic [WIDTH-1:0]      x_data,
   output logic                  x_ready,
   output logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [WIDTH-1:0]      w_data,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   input  logic                  out_ready,
   output logic                  busy
);
   state_t state, state_n;
   logic [WIDTH-1:0] x_q;
   logic mul_v, accept, last, done;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0] acc, sum;
   logic [WIDTH-1:0] r;
   assign x_ready = state == ACCUM;
   assign accept = x_valid & x_ready;
   assign last = accept && w_addr == ADDR_WIDTH'(NUM_INPUTS-1);
   assign done = out_valid & out_ready;
   // operands sign-extended to full product width so the low 2*WIDTH bits are the signed product
   assign prod = $signed({{WIDTH{x_q[WIDTH-1]}}, x_q}) * $signed({{WIDTH{w_data[WIDTH-1]}}, w_data});
   assign sum = acc + $signed({{(ACC_WIDTH-WIDTH-FRAC){w_data[WIDTH-1]}}, w_data, {FRAC{1'b0}}});
   q_round_sat #(.ACC_WIDTH(ACC_WIDTH), .WIDTH(WIDTH), .FRAC(FRAC), .RELU(RELU)) u_rs (.s(sum), .r(r));
   always_comb begin
      state_n = state;
      state_n = (state == ACCUM) ? (last ? DRAIN : ACCUM) :
                (state == DRAIN) ? BIAS :
                (state == BIAS)  ? OUT  : (done ? ACCUM : OUT);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
         w_addr <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         busy <= 1'b0;
         acc <= '0;
         mul_v <= 1'b0;
         x_q <= '0;
      end else begin
         state <= state_n;
         mul_v <= accept;
         if (accept) begin
            x_q <= x_data;
            w_addr <= w_addr + 1'b1;
            busy <= 1'b1;
         end
         if (mul_v) acc <= acc + {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
         if (state == BIAS) begin
            out_data <= r;
            out_valid <= 1'b1;
         end
         if (done) begin
            out_valid <= 1'b0;
            acc <= '0;
            w_addr <= '0;
            busy <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_neuron_mac_engine.sv
// tb_neuron_mac_engine: directed vectors against RELU=1 and RELU=0 instances sharing one stimulus
module tb_neuron_mac_engine;
   localparam int N = 4;
   logic clk = 1'b0, rst = 1'b1, x_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] x_data = '0;
   logic x_ready_a, x_ready_b, out_valid_a, out_valid_b, busy_a, busy_b;
   logic [2:0] w_addr_a, w_addr_b;
   logic [15:0] w_data_a, w_data_b, out_data_a, out_data_b;
   logic [15:0] mem [0:N];
   int max_addr;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      w_data_a <= mem[w_addr_a];
      w_data_b <= mem[w_addr_b];
      if (rst) max_addr <= 0;
      else if (int'(w_addr_a) > max_addr) max_addr <= int'(w_addr_a);
   end

   neuron_mac_engine #(.NUM_INPUTS(N), .RELU(1'b1)) dut_a (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready_a),
      .w_addr(w_addr_a), .w_data(w_data_a), .out_valid(out_valid_a), .out_data(out_data_a),
      .out_ready(out_ready), .busy(busy_a));
   neuron_mac_engine #(.NUM_INPUTS(N), .RELU(1'b0)) dut_b (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready_b),
      .w_addr(w_addr_b), .w_data(w_data_b), .out_valid(out_valid_b), .out_data(out_data_b),
      .out_ready(out_ready), .busy(busy_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input string tag, input logic [3:0][15:0] xv, input bit bubbles, input int n);
      for (int i = 0; i < n; i++) begin
         if (bubbles) repeat ($urandom_range(0, 3)) begin
            x_valid = 1'b0;
            @(negedge clk);
         end
         chk({tag, "_addr"}, w_addr_a, i);
         x_valid = 1'b1;
         x_data = xv[i];
         @(negedge clk);
      end
      x_valid = 1'b0;
   endtask

   task automatic vec(input string tag, input logic [3:0][15:0] xv, input logic [15:0] w,
                      input logic [15:0] bias, input logic [15:0] exp_a, input logic [15:0] exp_b,
                      input bit bubbles, input bit stall);
      logic [15:0] ra;
      bit ok;
      for (int i = 0; i < N; i++) mem[i] = w;
      mem[N] = bias;
      send(tag, xv, bubbles, N);
      chk({tag, "_t1_valid"}, out_valid_a, 0);
      chk({tag, "_t1_addr"}, w_addr_a, N);
      chk({tag, "_t1_busy"}, busy_a, 1);
      @(negedge clk);
      chk({tag, "_t2_valid"}, out_valid_a, 0);
      @(negedge clk);
      chk({tag, "_t3_valid"}, {out_valid_a, out_valid_b}, 2'b11);
      chk({tag, "_relu1"}, out_data_a, exp_a);
      chk({tag, "_relu0"}, out_data_b, exp_b);
      ra = out_data_a;
      if (stall) begin
         ok = 1'b1;
         x_valid = 1'b1;
         x_data = 16'h7fff;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_data_a !== ra || out_valid_a !== 1'b1 || x_ready_a !== 1'b0 || w_addr_a !== 3'(N)) ok = 1'b0;
         end
         x_valid = 1'b0;
         chk({tag, "_stall_stable"}, ok, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_post_hs"}, {out_valid_a, x_ready_a, busy_a, w_addr_a}, {1'b0, 1'b1, 1'b0, 3'd0});
   endtask

   initial begin
      for (int i = 0; i <= N; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_state", {out_valid_a, busy_a, w_addr_a, out_data_a}, '0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_x_ready", {x_ready_a, x_ready_b}, 2'b11);
      vec("s1", {4{16'h2000}}, 16'h2000, 16'h1000, 16'h5000, 16'h5000, 1'b0, 1'b0);
      vec("s2_pos", {4{16'h4000}}, 16'h2000, 16'h1000, 16'h7fff, 16'h7fff, 1'b0, 1'b0);
      vec("s2_neg", {4{16'h4000}}, 16'ha000, 16'h1000, 16'h0000, 16'h8000, 1'b0, 1'b0);
      vec("s3", {4{16'h2000}}, 16'he000, 16'h1000, 16'h0000, 16'hd000, 1'b0, 1'b0);
      vec("s4", {4{16'h2000}}, 16'h2000, 16'h1000, 16'h5000, 16'h5000, 1'b1, 1'b1);
      for (int i = 0; i < N; i++) mem[i] = 16'h2000;
      mem[N] = 16'h1000;
      send("s5_part", {4{16'h4000}}, 1'b0, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("s5_rst", {w_addr_a, out_valid_a, x_ready_a, busy_a}, {3'd0, 1'b0, 1'b1, 1'b0});
      vec("s5", {4{16'h2000}}, 16'h2000, 16'h1000, 16'h5000, 16'h5000, 1'b0, 1'b0);
      vec("s6", {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 16'h2000, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0);
      chk("s6_max_addr", max_addr, N);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
